// File: rtl/instr_encoder_loader_if.sv
// Request, instruction-memory write port and status bundle for instr_encoder_loader.
// master = sequencer/bench side, slave = loader side.
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_class;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [4:0]        in_shamt;
  logic [5:0]        in_funct;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              in_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   count;
  logic              done;
  logic              full;
  logic              err;
  logic [1:0]        dbg_state;

  modport master (
    output start, in_valid, in_class, in_rs, in_rt, in_rd, in_shamt,
           in_funct, in_imm, in_target, in_last,
    input  in_ready, imem_we, imem_addr, imem_wdata, count, done, full,
           err, dbg_state
  );

  modport slave (
    input  start, in_valid, in_class, in_rs, in_rt, in_rd, in_shamt,
           in_funct, in_imm, in_target, in_last,
    output in_ready, imem_we, imem_addr, imem_wdata, count, done, full,
           err, dbg_state
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Encodes symbolic MIPS requests and writes them sequentially into instruction memory.
// Optional ENC_ABS_BRANCH_EN: absolute branch targets converted to PC-relative offsets.
module instr_encoder_loader #(
  parameter int ADDR_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  instr_encoder_loader_if.slave  bus
);
  // Handshake: a request is taken on a rising edge where in_valid & in_ready.
  // in_ready is high only in IDLE with start low; each accept yields one WRITE cycle.
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE, S_FULL} state_t;

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [31:0]       word_q, word_d;
  logic              last_q, last_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] ptr;
  logic [5:0]        opcode;
  logic [15:0]       imm;
  logic [31:0]       word_enc;
  logic              reject;

  // Pointer tracks count; count only reaches 2^ADDR_W in FULL, where no write happens.
  assign ptr = count_q[ADDR_W-1:0];

`ifdef ENC_ABS_BRANCH_EN
  logic [ADDR_W:0] br_off;
  assign br_off = {1'b0, bus.in_target[ADDR_W-1:0]} - ({1'b0, ptr} + ONE);
`endif

  always_comb begin
    opcode = 6'b000000;
    case (bus.in_class)
      3'd0: opcode = 6'b000000;
      3'd1: opcode = 6'b001000;
      3'd2: opcode = 6'b000100;
      3'd3: opcode = 6'b000101;
      3'd4: opcode = 6'b100011;
      3'd5: opcode = 6'b101011;
      3'd6: opcode = 6'b001010;
      3'd7: opcode = 6'b000010;
      default: opcode = 6'b000000;
    endcase
    imm    = bus.in_imm;
    reject = 1'b0;
`ifdef ENC_ABS_BRANCH_EN
    if (bus.in_class == 3'd2 || bus.in_class == 3'd3) begin
      imm = 16'($signed(br_off));
    end
    if (bus.in_class == 3'd2 || bus.in_class == 3'd3 || bus.in_class == 3'd7) begin
      reject = (bus.in_target >> ADDR_W) != 26'd0;
    end
`endif
    case (bus.in_class)
      3'd0:    word_enc = {opcode, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_shamt, bus.in_funct};
      3'd7:    word_enc = {opcode, bus.in_target};
      default: word_enc = {opcode, bus.in_rs, bus.in_rt, imm};
    endcase
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    word_d  = word_q;
    last_d  = last_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          count_d = '0;
        end else if (bus.in_valid) begin
          if (reject) begin
            err_d = 1'b1;
          end else begin
            word_d  = word_enc;
            last_d  = bus.in_last;
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        // The write in progress always completes; start only clears afterwards.
        if (bus.start) begin
          count_d = '0;
          state_d = S_IDLE;
        end else begin
          count_d = count_q + ONE;
          if (last_q)                       state_d = S_DONE;
          else if (count_q + ONE == DEPTH)  state_d = S_FULL;
          else                              state_d = S_IDLE;
        end
      end
      S_DONE, S_FULL: begin
        if (bus.start) begin
          count_d = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      word_q  <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      word_q  <= word_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready   = (state_q == S_IDLE) && !bus.start;
  assign bus.imem_we    = (state_q == S_WRITE);
  assign bus.imem_addr  = bus.imem_we ? ptr : '0;
  assign bus.imem_wdata = bus.imem_we ? word_q : 32'd0;
  assign bus.count      = count_q;
  assign bus.done       = (state_q == S_DONE);
  assign bus.full       = (state_q == S_FULL);
  assign bus.err        = err_q;
  assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomized + directed bench for instr_encoder_loader against a transaction-level model.
module tb_instr_encoder_loader;
  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_encoder_loader_if #(.ADDR_W(AW)) bus();
  instr_encoder_loader #(.ADDR_W(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    bit valid;
    int cls, rs, rt, rd, sh, fn, imm, tgt;
    bit last;
    bit st;
  } req_t;

  int n_checks = 0;
  int n_pass   = 0;
  int op_tab[8] = '{0, 8, 4, 5, 35, 43, 10, 2};

  // Reference model: words written so far, outstanding write, sticky status.
  int          m_count;
  bit          m_pend, m_last, m_done, m_full, m_err;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] enc(input req_t r, input int ptr);
    logic [31:0] op;
    int          imm;
    op  = op_tab[r.cls];
    imm = r.imm;
`ifdef ENC_ABS_BRANCH_EN
    if (r.cls == 2 || r.cls == 3) imm = (r.tgt % DEPTH) - (ptr + 1);
`endif
    if (r.cls == 0)
      return (op << 26) | (r.rs << 21) | (r.rt << 16) | (r.rd << 11) | (r.sh << 6) | r.fn;
    if (r.cls == 7)
      return (op << 26) | (r.tgt & 32'h03FF_FFFF);
    return (op << 26) | (r.rs << 21) | (r.rt << 16) | (imm & 32'h0000_FFFF);
  endfunction

  function automatic bit rejected(input req_t r);
`ifdef ENC_ABS_BRANCH_EN
    return (r.cls == 2 || r.cls == 3 || r.cls == 7) && (r.tgt >= DEPTH);
`else
    return (r.cls < 0);
`endif
  endfunction

  function automatic req_t mk(input int cls, rs, rt, rd, sh, fn, imm, tgt, input bit last);
    req_t r;
    r = '{valid: 1'b1, cls: cls, rs: rs, rt: rt, rd: rd, sh: sh, fn: fn,
          imm: imm, tgt: tgt, last: last, st: 1'b0};
    return r;
  endfunction

  function automatic req_t idle(input bit st);
    req_t r;
    r = '{default: 0};
    r.st = st;
    return r;
  endfunction

  function automatic req_t rnd_req();
    req_t r;
    r.valid = ($urandom_range(0, 3) != 0);
    r.cls   = $urandom_range(0, 7);
    r.rs    = $urandom_range(0, 31);
    r.rt    = $urandom_range(0, 31);
    r.rd    = $urandom_range(0, 31);
    r.sh    = $urandom_range(0, 31);
    r.fn    = $urandom_range(0, 63);
    r.imm   = $urandom_range(0, 65535);
    r.tgt   = ($urandom_range(0, 1) != 0) ? $urandom_range(0, DEPTH - 1)
                                          : int'($urandom & 32'h03FF_FFFF);
    r.last  = ($urandom_range(0, 9) == 0);
    r.st    = ($urandom_range(0, 19) == 0);
    return r;
  endfunction

  task automatic model_reset();
    m_count = 0; m_pend = 0; m_last = 0; m_done = 0; m_full = 0; m_err = 0;
    exp_q.delete();
  endtask

  task automatic model_edge(input req_t r);
    bit new_err;
    new_err = 0;
    if (m_pend) begin
      m_pend  = 0;
      m_count = r.st ? 0 : m_count + 1;
      if (!r.st && m_last)                m_done = 1;
      else if (!r.st && m_count == DEPTH) m_full = 1;
    end else if (r.st) begin
      m_count = 0; m_done = 0; m_full = 0;
    end else if (!m_done && !m_full && r.valid) begin
      if (rejected(r)) new_err = 1;
      else begin
        exp_q.push_back(enc(r, m_count % DEPTH));
        m_pend = 1;
        m_last = r.last;
      end
    end
    m_err = new_err;
  endtask

  // Drive at the falling edge, check mid-low phase, advance model at the rising edge.
  task automatic cycle(input req_t r);
    bus.start     = r.st;
    bus.in_valid  = r.valid;
    bus.in_class  = 3'(r.cls);
    bus.in_rs     = 5'(r.rs);
    bus.in_rt     = 5'(r.rt);
    bus.in_rd     = 5'(r.rd);
    bus.in_shamt  = 5'(r.sh);
    bus.in_funct  = 6'(r.fn);
    bus.in_imm    = 16'(r.imm);
    bus.in_target = 26'(r.tgt);
    bus.in_last   = r.last;
    #1;
    chk("in_ready", 32'(bus.in_ready), 32'(!m_pend && !m_done && !m_full && !r.st));
    chk("imem_we", 32'(bus.imem_we), 32'(m_pend));
    chk("imem_addr", 32'(bus.imem_addr), m_pend ? m_count % DEPTH : 0);
    if (m_pend) chk("imem_wdata", bus.imem_wdata, exp_q.pop_front());
    else        chk("imem_wdata_idle", bus.imem_wdata, 0);
    chk("count", 32'(bus.count), m_count);
    chk("done", 32'(bus.done), 32'(m_done));
    chk("full", 32'(bus.full), 32'(m_full));
    chk("err", 32'(bus.err), 32'(m_err));
    @(posedge clk);
    model_edge(r);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 0; bus.in_valid = 0; bus.in_class = 0; bus.in_rs = 0; bus.in_rt = 0;
    bus.in_rd = 0; bus.in_shamt = 0; bus.in_funct = 0; bus.in_imm = 0;
    bus.in_target = 0; bus.in_last = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_ready", 32'(bus.in_ready), 1);
    chk("rst_we", 32'(bus.imem_we), 0);
    chk("rst_count", 32'(bus.count), 0);
    reset = 1'b0;
    cycle(idle(0));

    // ADDI after reset
    cycle(mk(1, 1, 2, 0, 0, 0, 16'h0005, 0, 0));
    #1 chk("addi_wdata", bus.imem_wdata, 32'h2022_0005);
    chk("addi_addr", 32'(bus.imem_addr), 0);
    cycle(idle(0));
    #1 chk("addi_count", 32'(bus.count), 1);
    chk("addi_ready", 32'(bus.in_ready), 1);

    // R-type then J with last
    cycle(idle(1));
    cycle(mk(0, 1, 2, 3, 0, 6'h20, 0, 0, 0));
    #1 chk("rtype_wdata", bus.imem_wdata, 32'h0022_1820);
    cycle(idle(0));
    cycle(mk(7, 0, 0, 0, 0, 0, 0, 26'h10, 1));
    #1 chk("j_wdata", bus.imem_wdata, 32'h0800_0010);
    chk("j_addr", 32'(bus.imem_addr), 1);
    cycle(idle(0));
    #1 chk("last_done", 32'(bus.done), 1);
    chk("last_count", 32'(bus.count), 2);
    chk("last_ready", 32'(bus.in_ready), 0);

    // Fill memory without last
    cycle(idle(1));
    for (int i = 0; i < DEPTH; i++) begin
      cycle(mk(1, i, 0, 0, 0, 0, i, 0, 0));
      cycle(idle(0));
    end
    #1 chk("fill_full", 32'(bus.full), 1);
    chk("fill_count", 32'(bus.count), DEPTH);
    cycle(mk(1, 5, 5, 0, 0, 0, 7, 0, 0));
    #1 chk("full_no_write", 32'(bus.imem_we), 0);
    cycle(idle(1));
    bus.start = 1'b0;
    #1 chk("restart_ready", 32'(bus.in_ready), 1);
    chk("restart_full", 32'(bus.full), 0);
    chk("restart_count", 32'(bus.count), 0);

    // Branch encoding at ptr=4, then J with high target bits
    for (int i = 0; i < 4; i++) begin
      cycle(mk(1, 0, 0, 0, 0, 0, i, 0, 0));
      cycle(idle(0));
    end
    cycle(mk(2, 1, 2, 0, 0, 0, 0, 2, 0));
`ifdef ENC_ABS_BRANCH_EN
    #1 chk("beq_wdata", bus.imem_wdata, 32'h1022_FFFD);
`else
    #1 chk("beq_wdata", bus.imem_wdata, 32'h1022_0000);
`endif
    cycle(idle(0));
    cycle(mk(7, 0, 0, 0, 0, 0, 0, 26'h100, 0));
`ifdef ENC_ABS_BRANCH_EN
    #1 chk("jhigh_err", 32'(bus.err), 1);
    chk("jhigh_we", 32'(bus.imem_we), 0);
`else
    #1 chk("jhigh_wdata", bus.imem_wdata, 32'h0800_0100);
`endif
    cycle(idle(0));

    // Asynchronous reset in the middle of a write
    cycle(idle(1));
    cycle(mk(1, 1, 1, 0, 0, 0, 1, 0, 0));
    cycle(idle(0));
    cycle(mk(1, 2, 2, 0, 0, 0, 2, 0, 0));
    #1 chk("arst_pre_we", 32'(bus.imem_we), 1);
    reset = 1'b1;
    #1 chk("arst_we", 32'(bus.imem_we), 0);
    chk("arst_count", 32'(bus.count), 0);
    chk("arst_addr", 32'(bus.imem_addr), 0);
    #1 reset = 1'b0;
    model_reset();
    cycle(mk(1, 3, 3, 0, 0, 0, 3, 0, 0));
    #1 chk("arst_reload_addr", 32'(bus.imem_addr), 0);
    chk("arst_reload_we", 32'(bus.imem_we), 1);
    cycle(idle(0));

    // start overrides a same-cycle request
    begin
      req_t r;
      r = mk(6, 4, 5, 0, 0, 0, 16'h1234, 0, 0);
      r.st = 1'b1;
      cycle(r);
      #1 chk("start_ovr_we", 32'(bus.imem_we), 0);
      chk("start_ovr_err", 32'(bus.err), 0);
      r.st = 1'b0;
      cycle(r);
      #1 chk("start_ovr_accept_we", 32'(bus.imem_we), 1);
      chk("start_ovr_addr", 32'(bus.imem_addr), 0);
      cycle(idle(0));
    end

    repeat (3000) cycle(rnd_req());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

- Encodes symbolic instruction requests into 32-bit MIPS words.
- Writes them sequentially into instruction memory through a single write port.
- Sits between the bench or boot sequencer and the instruction memory.
- Produces exactly the opcode set the control decoder understands: R-type, ADDI, BEQ, BNE, LW, SW, SLTI, J.

## Interface
Parameters:
- ADDR_W, 8, instruction-memory word-address width (depth 2^ADDR_W words); legal range 2..15

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  restart load: pointer and status cleared
- in_valid  in  1  request valid
- in_ready  out  1  request can be accepted
- in_class  in  3  0 R-type, 1 ADDI, 2 BEQ, 3 BNE, 4 LW, 5 SW, 6 SLTI, 7 J
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register / shift fields
- in_funct  in  6  R-type function field
- in_imm  in  16  immediate / raw branch offset
- in_target  in  26  jump target; absolute branch target when configured
- in_last  in  1  final instruction of the program
- imem_we  out  1  memory write strobe
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  32  encoded instruction
- count  out  ADDR_W+1  words written since start/reset
- done  out  1  in_last word written
- full  out  1  memory filled without in_last
- err  out  1  one-cycle pulse: request rejected

## Operation
- Opcodes by class: 000000, 001000, 000100, 000101, 100011, 101011, 001010, 000010.
- R-type word: {op, rs, rt, rd, shamt, funct}.
- I-type word (classes 1–6): {op, rs, rt, imm}.
- J word: {op, target}.
- States:
  - IDLE: in_ready=1 unless start is high.
  - WRITE: in_ready=0.
  - DONE: in_ready=0.
  - FULL: in_ready=0.
- IDLE, handshake (in_valid & in_ready): register encoded word and in_last, go to WRITE.
- WRITE: exactly one cycle.
  - imem_we=1, imem_addr=ptr, imem_wdata=registered word.
  - On exit: ptr+1, count+1.
  - Next state: DONE if last; else FULL if count reaches 2^ADDR_W; else IDLE.
- DONE/FULL: hold until start or reset.
  - done/full is high only in its own state.
- start, in any state:
  - Next cycle: ptr=0, count=0, state IDLE.
  - Overrides a same-cycle handshake; no accept occurs.
  - If start is high during WRITE, that write still completes, then ptr/count clear.
- Throughput: one instruction per 2 cycles.
- Reset values: in_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, count=0, done=0, full=0, err=0, state IDLE.

## Timing
- Handshake at edge N: imem_we high in cycle N+1.
- imem_wdata and imem_addr are registered and stable for the whole WRITE cycle.
- imem_addr is 0 outside WRITE.
- err: registered pulse in the cycle after the rejected handshake.
  - State stays IDLE; no write, ptr/count unchanged.
  - The request is consumed.
- Wrap-around: impossible, since FULL blocks further accepts. count reaches 2^ADDR_W exactly (hence the ADDR_W+1 width).
- in_last on the final free word gives DONE, not FULL; DONE takes priority.
- Asynchronous reset mid-WRITE:
  - imem_we drops immediately.
  - Everything else returns to reset values without waiting for a clock edge.
  - The partial load is abandoned.

## Configuration
- ENC_ABS_BRANCH_EN defined:
  - BEQ/BNE immediate = in_target[ADDR_W-1:0] − (ptr+1), computed signed in ADDR_W+1 bits and sign-extended to 16; in_imm ignored.
  - BEQ/BNE/J with any in_target[25:ADDR_W] bit set: rejected, with err.
- ENC_ABS_BRANCH_EN undefined:
  - Branches use in_imm unchanged.
  - J uses in_target unchanged.
  - err is constant 0.

## Test plan
- ADDI rs=1 rt=2 imm=0x0005 after reset -> cycle N+1: imem_we=1, addr=0, wdata=0x20220005; then count=1, in_ready=1.
- R-type rs=1 rt=2 rd=3 shamt=0 funct=0x20, then J target=0x10 with in_last -> wdata 0x00221820 at addr 0, 0x08000010 at addr 1; done=1, count=2, in_ready=0.
- ADDR_W=2, four back-to-back requests (none last) -> addrs 0..3, full=1, count=4; a fifth in_valid is not accepted; start -> count=0, full=0, in_ready=1.
- ENC_ABS_BRANCH_EN, ptr=4, BEQ rs=1 rt=2 in_target=2 -> wdata 0x1022FFFD; J in_target=0x100 with ADDR_W=8 -> err pulse, no write.
- Async reset asserted mid-WRITE -> imem_we=0 with no clock edge; after release count=0 and addr-0 load works.
- start and in_valid in the same IDLE cycle -> no accept, no err; request accepted on the following cycle at addr 0.
